// File: rtl/spi_master_ctrl_pkg.sv
// Shared SPI framing constants, controller state encoding and command payload.
package spi_master_ctrl_pkg;

  localparam int unsigned SPI_CMD_RW_BIT = 7;
  localparam int unsigned SPI_FRAME_BITS = 16;
  localparam int unsigned SPI_BYTE_W     = 8;
  localparam int unsigned SPI_ADDR_MAX_W = 7;
  localparam int unsigned SPI_BIT_CNT_W  = 4;

  localparam logic SPI_RD = 1'b1;
  localparam logic SPI_WR = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic                      rw;
    logic [SPI_ADDR_MAX_W-1:0] addr;
    logic [SPI_BYTE_W-1:0]     wdata;
  } cmd_t;

  // Frame as sent on mosi, MSB first: command byte then data byte (zero on reads).
  function automatic logic [SPI_FRAME_BITS-1:0] build_frame(input cmd_t cmd);
    logic [SPI_BYTE_W-1:0] cmd_byte;
    logic [SPI_BYTE_W-1:0] data_byte;
    cmd_byte                 = {1'b0, cmd.addr};
    cmd_byte[SPI_CMD_RW_BIT] = cmd.rw;
    data_byte                = (cmd.rw == SPI_WR) ? cmd.wdata : '0;
    return {cmd_byte, data_byte};
  endfunction

endpackage

// File: rtl/spi_master_ctrl_sclk_gen.sv
// SPI clock divider: sclk toggles every CLK_DIV enabled cycles, idles low when disabled.
module spi_master_ctrl_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_tick_c,
  output logic fall_tick_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             half_end_c;

  // Strobes mark the cycle whose closing edge flips sclk.
  assign half_end_c  = en && (div_cnt == DIV_LAST);
  assign rise_tick_c = half_end_c && !sclk;
  assign fall_tick_c = half_end_c && sclk;

  // Half-period counter and sclk flop; both cleared whenever the divider is disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (half_end_c) begin
      div_cnt <= '0;
      sclk    <= !sclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: one register command becomes a 16-bit mode-0 frame.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [SPI_BYTE_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [SPI_BYTE_W-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int unsigned PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(CS_HOLD - 1);
  localparam logic [SPI_BIT_CNT_W-1:0] BIT_LAST = SPI_BIT_CNT_W'(SPI_FRAME_BITS - 1);

  state_e                    state_q;
  state_e                    state_d;
  logic                      cs_n_d;
  logic                      busy_d;
  logic                      ready_d;
  logic                      rsp_valid_d;
  logic                      accept_c;
  logic                      shift_en_c;
  logic                      rise_tick_c;
  logic                      fall_tick_c;
  cmd_t                      cmd_c;
  logic                      rw_q;
  logic [SPI_FRAME_BITS-1:0] tx_q;
  logic [SPI_BYTE_W-1:0]     rx_q;
  logic [PH_W-1:0]           ph_cnt_q;
  logic [SPI_BIT_CNT_W-1:0]  bit_cnt_q;

  assign accept_c   = cmd_valid && cmd_ready;
  assign shift_en_c = (state_q == ST_SHIFT);
  assign cmd_c      = '{rw: cmd_rw, addr: SPI_ADDR_MAX_W'(cmd_addr), wdata: cmd_wdata};

  // mosi is the top bit of the tx shift register, so it comes straight from a flop.
  assign mosi = tx_q[SPI_FRAME_BITS-1];

  spi_master_ctrl_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk         (clk),
    .rst         (rst),
    .en          (shift_en_c),
    .sclk        (sclk),
    .rise_tick_c (rise_tick_c),
    .fall_tick_c (fall_tick_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, plus output values decoded from the next state so they register in step.
  always_comb begin
    state_d     = state_q;
    cs_n_d      = 1'b1;
    busy_d      = 1'b1;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE:  if (accept_c) state_d = ST_SETUP;
      ST_SETUP: if (ph_cnt_q == SETUP_LAST) state_d = ST_SHIFT;
      ST_SHIFT: if (fall_tick_c && (bit_cnt_q == BIT_LAST)) state_d = ST_HOLD;
      ST_HOLD:  if (ph_cnt_q == HOLD_LAST) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_IDLE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      ST_SETUP, ST_SHIFT, ST_HOLD: cs_n_d = 1'b0;
      ST_DONE: rsp_valid_d = 1'b1;
      default: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // Registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      cs_n      <= cs_n_d;
      busy      <= busy_d;
      cmd_ready <= ready_d;
      rsp_valid <= rsp_valid_d;
    end
  end

  // Command capture and MSB-first transmit shifting on each falling sclk.
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q <= 1'b0;
      tx_q <= '0;
    end else if (accept_c) begin
      rw_q <= cmd_c.rw;
      tx_q <= build_frame(cmd_c);
    end else if (fall_tick_c) begin
      tx_q <= {tx_q[SPI_FRAME_BITS-2:0], 1'b0};
    end
  end

  // SPI bit index; advances on falling sclk and clears at frame end or in idle.
  always_ff @(posedge clk) begin
    if (rst || (state_q == ST_IDLE)) begin
      bit_cnt_q <= '0;
    end else if (fall_tick_c) begin
      bit_cnt_q <= (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + SPI_BIT_CNT_W'(1);
    end
  end

  // Setup/hold dwell counter; restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst || (state_d != state_q)) begin
      ph_cnt_q <= '0;
    end else if ((state_q == ST_SETUP) || (state_q == ST_HOLD)) begin
      ph_cnt_q <= ph_cnt_q + PH_W'(1);
    end
  end

  // Read data arrives LSB first in bits 8..15; sampled just before each rising sclk.
  always_ff @(posedge clk) begin
    if (rst || accept_c) begin
      rx_q <= '0;
    end else if (rise_tick_c && bit_cnt_q[SPI_BIT_CNT_W-1] && (rw_q == SPI_RD)) begin
      rx_q[bit_cnt_q[2:0]] <= miso;
    end
  end

  // Response data updates only when the frame completes and holds until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
    end else if (state_d == ST_DONE) begin
      rsp_rdata <= rx_q;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: default-timing and fastest-timing instances, bus-level monitor.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned A_DIV   = 4;
  localparam int unsigned A_SETUP = 2;
  localparam int unsigned A_HOLD  = 2;
  localparam int unsigned B_DIV   = 1;
  localparam int unsigned B_SETUP = 1;
  localparam int unsigned B_HOLD  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_rw = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [7:0]        cmd_wdata = '0;
  logic              miso = 1'b0;
  bit                sel = 1'b0;

  logic cmd_valid_a, ready_a, rsp_valid_a, busy_a, sclk_a, cs_n_a, mosi_a;
  logic cmd_valid_b, ready_b, rsp_valid_b, busy_b, sclk_b, cs_n_b, mosi_b;
  logic [7:0] rdata_a, rdata_b;

  assign cmd_valid_a = cmd_valid && !sel;
  assign cmd_valid_b = cmd_valid && sel;

  logic ready_m, rsp_valid_m, busy_m, sclk_m, cs_m, mosi_m;
  logic [7:0] rdata_m;
  assign ready_m     = sel ? ready_b     : ready_a;
  assign rsp_valid_m = sel ? rsp_valid_b : rsp_valid_a;
  assign busy_m      = sel ? busy_b      : busy_a;
  assign sclk_m      = sel ? sclk_b      : sclk_a;
  assign cs_m        = sel ? cs_n_b      : cs_n_a;
  assign mosi_m      = sel ? mosi_b      : mosi_a;
  assign rdata_m     = sel ? rdata_b     : rdata_a;

  spi_master_ctrl #(.CLK_DIV(A_DIV), .CS_SETUP(A_SETUP), .CS_HOLD(A_HOLD), .ADDR_W(ADDR_W)) u_dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(ready_a), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a),
    .busy(busy_a), .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso)
  );

  spi_master_ctrl #(.CLK_DIV(B_DIV), .CS_SETUP(B_SETUP), .CS_HOLD(B_HOLD), .ADDR_W(ADDR_W)) u_dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(ready_b), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid_b), .rsp_rdata(rdata_b),
    .busy(busy_b), .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: frame contents and timing straight from the protocol rules.
  function automatic logic [15:0] model_bits(input logic rw, input logic [ADDR_W-1:0] addr,
                                             input logic [7:0] wd);
    int v;
    v = (int'(rw) << 15) | (int'(addr) << 8) | (rw ? 0 : int'(wd));
    return 16'(v);
  endfunction

  function automatic int div_of(input bit s);
    return s ? int'(B_DIV) : int'(A_DIV);
  endfunction

  function automatic int len_of(input bit s);
    return s ? int'(B_SETUP + 32 * B_DIV + B_HOLD) : int'(A_SETUP + 32 * A_DIV + A_HOLD);
  endfunction

  // Bus monitor and slave model: one record per cs_n-low window.
  typedef struct {
    logic [15:0] bits;
    int          rises;
    int          len;
    bit          bad_t;
    bit          bad_m;
    int          gap;
    logic        rsp;
    logic [7:0]  rdata;
  } frame_t;

  frame_t     frames[$];
  logic [7:0] slave_q[$];
  logic [15:0] f_bits;
  int          f_rises = 0;
  int          f_len, f_gap, gap_cnt = 0, high_run, low_run;
  bit          f_bad_t, f_bad_m;
  logic [7:0]  f_rbyte;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  int          rsp_pulses = 0;
  int          idle_bad = 0;

  always @(negedge clk) begin
    if (rsp_valid_m === 1'b1) rsp_pulses++;
    if (!cs_m && prev_cs) begin
      f_bits = '0; f_rises = 0; f_len = 0; f_bad_t = 0; f_bad_m = 0;
      f_gap = gap_cnt; high_run = 0; low_run = 0;
      f_rbyte = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
    end
    if (!cs_m) begin
      f_len++;
      if (sclk_m && !prev_sclk) begin
        f_rises++;
        if (f_rises > 1 && low_run != div_of(sel)) f_bad_t = 1;
        if (f_rises <= 16) f_bits = {f_bits[14:0], mosi_m};
        high_run = 1;
        if (f_rises >= 8 && f_rises <= 15) miso = f_rbyte[f_rises-8];
        else miso = 1'($urandom);
      end else if (sclk_m) begin
        high_run++;
      end
      if (!sclk_m && prev_sclk) begin
        if (high_run != div_of(sel)) f_bad_t = 1;
        low_run = 1;
      end else if (!sclk_m) begin
        low_run++;
      end
      if (!prev_cs && (mosi_m !== prev_mosi) && !(prev_sclk && !sclk_m)) f_bad_m = 1;
    end else begin
      if (!prev_cs) begin
        frames.push_back('{bits: f_bits, rises: f_rises, len: f_len, bad_t: f_bad_t,
                           bad_m: f_bad_m, gap: f_gap, rsp: rsp_valid_m, rdata: rdata_m});
        f_rises = 0;
        gap_cnt = 0;
      end
      gap_cnt++;
      if (sclk_m !== 1'b0) idle_bad++;
    end
    prev_cs   = cs_m;
    prev_sclk = sclk_m;
    prev_mosi = mosi_m;
  end

  task automatic send(input logic rw, input logic [ADDR_W-1:0] addr, input logic [7:0] wd);
    int n = 0;
    @(negedge clk);
    cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    while (!ready_m && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_rw = 1'($urandom); cmd_addr = ADDR_W'($urandom); cmd_wdata = 8'($urandom);
    check("busy_after_accept", 32'(busy_m), 1);
    check("ready_after_accept", 32'(ready_m), 0);
  endtask

  task automatic get_frame(output frame_t f);
    int n = 0;
    while (frames.size() == 0 && n < 3000) begin @(negedge clk); n++; end
    if (frames.size() == 0) begin
      check("frame_timeout", 0, 1);
      f = '{bits: '0, rises: 0, len: 0, bad_t: 1'b0, bad_m: 1'b0, gap: 0, rsp: 1'b0, rdata: '0};
    end else begin
      f = frames.pop_front();
    end
  endtask

  task automatic check_frame(input frame_t f, input logic [15:0] eb, input logic [7:0] er,
                             input int el, input string tag);
    check({tag, "_mosi_bits"}, 32'(f.bits), 32'(eb));
    check({tag, "_rises"}, f.rises, 16);
    check({tag, "_cs_low_len"}, f.len, el);
    check({tag, "_rsp_valid"}, 32'(f.rsp), 1);
    check({tag, "_rdata"}, 32'(f.rdata), 32'(er));
    check({tag, "_sclk_timing"}, 32'(f.bad_t), 0);
    check({tag, "_mosi_stable"}, 32'(f.bad_m), 0);
  endtask

  typedef struct {
    bit          sel;
    logic        rw;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rbyte;
    logic [15:0] exp_bits;
    logic [7:0]  exp_rdata;
    int          exp_len;
  } vec_t;

  vec_t   vecs[7];
  frame_t fr;
  frame_t fr2;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    bit rdy_bad;

    vecs[0] = '{0, 1'b0, 6'h05, 8'hA5, 8'h5A, 16'h05A5, 8'h00, 132};
    vecs[1] = '{0, 1'b1, 6'h12, 8'h77, 8'h3C, 16'h9200, 8'h3C, 132};
    vecs[2] = '{0, 1'b0, 6'h3F, 8'hFF, 8'h00, 16'h3FFF, 8'h00, 132};
    vecs[3] = '{0, 1'b1, 6'h00, 8'h00, 8'h81, 16'h8000, 8'h81, 132};
    vecs[4] = '{1, 1'b1, 6'h2A, 8'h5F, 8'hFF, 16'hAA00, 8'hFF, 34};
    vecs[5] = '{1, 1'b1, 6'h15, 8'hFF, 8'h00, 16'h9500, 8'h00, 34};
    vecs[6] = '{1, 1'b0, 6'h01, 8'hC3, 8'hAA, 16'h01C3, 8'h00, 34};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state of both instances.
    check("rst_a_ready", 32'(ready_a), 1);
    check("rst_a_cs_n", 32'(cs_n_a), 1);
    check("rst_a_sclk", 32'(sclk_a), 0);
    check("rst_a_mosi", 32'(mosi_a), 0);
    check("rst_a_rsp_valid", 32'(rsp_valid_a), 0);
    check("rst_a_rdata", 32'(rdata_a), 0);
    check("rst_a_busy", 32'(busy_a), 0);
    check("rst_b_ready", 32'(ready_b), 1);
    check("rst_b_cs_n", 32'(cs_n_b), 1);
    check("rst_b_sclk", 32'(sclk_b), 0);

    // Directed vectors, both timing configurations.
    for (int i = 0; i < 7; i++) begin
      sel = vecs[i].sel;
      slave_q.push_back(vecs[i].rbyte);
      send(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      get_frame(fr);
      check_frame(fr, vecs[i].exp_bits, vecs[i].exp_rdata, vecs[i].exp_len, $sformatf("vec%0d", i));
    end

    // Command pulsed mid-frame is ignored and not queued.
    sel = 1'b0;
    slave_q.push_back(8'h00);
    send(1'b0, 6'h2A, 8'h3C);
    n = 0;
    while (f_rises < 4 && n < 2000) begin @(negedge clk); n++; end
    rdy_bad = 1'b0;
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 6'h11; cmd_wdata = 8'hEE;
    repeat (3) begin
      if (ready_m) rdy_bad = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    p0 = rsp_pulses;
    n = 0;
    while (frames.size() == 0 && n < 3000) begin
      if (busy_m && ready_m) rdy_bad = 1'b1;
      @(negedge clk); n++;
    end
    get_frame(fr);
    check_frame(fr, 16'h2A3C, 8'h00, 132, "busy_ignore");
    check("busy_ready_low", 32'(rdy_bad), 0);
    repeat (20) @(negedge clk);
    check("busy_one_rsp", rsp_pulses - p0, 1);
    check("busy_no_queued_frame", frames.size(), 0);

    // Back-to-back commands with cmd_valid held high.
    slave_q.push_back(8'hC5);
    slave_q.push_back(8'h00);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 6'h07; cmd_wdata = 8'h11;
    n = 0;
    while (!ready_m && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_rw = 1'b0; cmd_addr = 6'h30; cmd_wdata = 8'h99;
    n = 0;
    while (!ready_m && n < 2000) begin @(negedge clk); n++; end
    check("b2b_second_accept", 32'(n < 2000), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    get_frame(fr);
    get_frame(fr2);
    check_frame(fr, 16'h8700, 8'hC5, 132, "b2b_first");
    check_frame(fr2, 16'h3099, 8'h00, 132, "b2b_second");
    check("b2b_cs_gap", fr2.gap, 2);

    // Reset in the middle of a frame.
    slave_q.push_back(8'h5A);
    p0 = rsp_pulses;
    send(1'b1, 6'h09, 8'h00);
    n = 0;
    while (f_rises < 5 && n < 2000) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", 32'(cs_n_a), 1);
    check("midrst_sclk", 32'(sclk_a), 0);
    check("midrst_mosi", 32'(mosi_a), 0);
    check("midrst_ready", 32'(ready_a), 1);
    check("midrst_busy", 32'(busy_a), 0);
    check("midrst_rsp_valid", 32'(rsp_valid_a), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    get_frame(fr);
    check("midrst_abort_no_rsp", 32'(fr.rsp), 0);
    check("midrst_no_more_frames", frames.size(), 0);
    check("midrst_no_rsp_pulse", rsp_pulses - p0, 0);

    // Randomized commands against the model.
    for (int i = 0; i < 20; i++) begin
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        wd;
      logic [7:0]        rb;
      sel  = 1'((i >> 1) & 1);
      rw   = 1'($urandom);
      addr = ADDR_W'($urandom);
      wd   = 8'($urandom);
      rb   = 8'($urandom);
      slave_q.push_back(rb);
      send(rw, addr, wd);
      get_frame(fr);
      check_frame(fr, model_bits(rw, addr, wd), rw ? rb : 8'h00, len_of(sel), $sformatf("rand%0d", i));
    end

    check("idle_sclk_low", idle_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
